// File: rtl/imem_dmem_arbiter_if.sv
// imem_dmem_arbiter_if
//   Bundles the fetch port, the data port, the memory port and the pipeline
//   status flags of the unified-memory arbiter.
//   slave  : arbiter side (samples requests and mem_rdata, drives the rest)
//   master : environment side (pipeline requesters plus the memory)
//   Signals: if_req/if_addr/if_ack/if_rdata, dm_req/dm_we/dm_addr/dm_wdata/
//            dm_ack/dm_rdata, mem_en/mem_we/mem_addr/mem_wdata/mem_rdata,
//            stall_if/stall_mem/busy.
interface imem_dmem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;
  logic          stall_mem;
  logic          busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem, busy
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//   Shares one single-port, fixed-latency memory between instruction fetch
//   (read-only) and the MEM-stage data port. Data port wins ties unless it
//   has already won DM_STREAK_MAX grants in a row while fetch was waiting.
//   Each access runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> ACK.
// Ports:
//   clk1  : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of imem_dmem_arbiter_if (requesters, memory, flags)
module imem_dmem_arbiter #(
  parameter int AW            = 10,
  parameter int DW            = 32,
  parameter int MEM_LAT       = 1,
  parameter int DM_STREAK_MAX = 4
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  imem_dmem_arbiter_if.slave    bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(DM_STREAK_MAX + 1);

  logic [1:0]    state_q, state_d;
  logic          own_dm_q, own_dm_d;   // owner of the access in flight
  logic          we_q, we_d;           // frozen store flag for WAIT
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          grant_dm;

  // Fetch only wins a tie once the data port has used up its streak.
  assign grant_dm = bus.dm_req && !(bus.if_req && (streak_q == SW'(DM_STREAK_MAX)));

  always_comb begin
    state_d     = state_q;
    own_dm_d    = own_dm_q;
    we_d        = we_q;
    wcnt_d      = wcnt_q;
    streak_d    = streak_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          state_d  = S_ISSUE;
          mem_en_d = 1'b1;
          own_dm_d = grant_dm;
          if (grant_dm) begin
            we_d       = bus.dm_we;
            mem_we_d   = bus.dm_we;
            mem_addr_d = bus.dm_addr;
            if (bus.dm_we) mem_wdata_d = bus.dm_wdata;
            // Streak only grows while fetch is actually being held off.
            if (!bus.if_req)                            streak_d = '0;
            else if (streak_q != SW'(DM_STREAK_MAX))    streak_d = streak_q + 1'b1;
          end else begin
            we_d       = 1'b0;
            mem_addr_d = bus.if_addr;
            streak_d   = '0;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wcnt_d  = CW'(MEM_LAT - 1);
      end
      S_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = S_ACK;
          if (own_dm_q) begin
            dm_ack_d = 1'b1;
            if (!we_q) dm_rdata_d = bus.mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      own_dm_q    <= 1'b0;
      we_q        <= 1'b0;
      wcnt_q      <= '0;
      streak_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      own_dm_q    <= own_dm_d;
      we_q        <= we_d;
      wcnt_q      <= wcnt_d;
      streak_q    <= streak_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_mem = bus.dm_req & ~dm_ack_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter
//   Directed and randomized fetch/load/store traffic against a latency-exact
//   memory model. A transaction-level reference (serialized accesses, shadow
//   memory, streak rule) pushes expected acks into a scoreboard queue; a
//   separate monitor pops on every DUT ack and checks per-cycle outputs.
module tb_imem_dmem_arbiter;
  localparam int AW = 10, DW = 32, LAT = 3, STREAK = 4;

  typedef struct {
    bit          dm;
    int          t;
    bit          has_data;
    logic [DW-1:0] data;
  } exp_t;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  imem_dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  imem_dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .DM_STREAK_MAX(STREAK)) dut (
    .clk1(clk1), .rst_n(rst_n), .bus(bus)
  );

  int nv = 0, nf = 0, cyc = 0;
  exp_t exp_q[$];
  bit   order_q[$];

  // reference model state
  bit            pend = 0, cur_dm = 0, cur_we = 0;
  int            t0 = 0, t_ack = 0, streak = 0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  logic [DW-1:0] shadow [1<<AW];

  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rpipe [LAT];
  assign bus.mem_rdata = rpipe[LAT-1];

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 0)   return 32'h480200d2;
    if (i == 210) return 32'd40;
    return (32'(i) * 32'h9E3779B9) ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nv++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk1);
    cyc++;
  end

  // memory: data for an access strobed in cycle c is on mem_rdata in c+LAT only
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = init_word(i);
    for (int i = 0; i < LAT; i++) rpipe[i] <= '0;
    forever begin
      @(posedge clk1);
      for (int i = LAT-1; i > 0; i--) rpipe[i] <= rpipe[i-1];
      rpipe[0] <= bus.mem_en ? mem[bus.mem_addr] : 32'hDEADBEEF;
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  // reference: one access at a time, decided from the requests the bench drives
  initial begin
    bit g;
    exp_t r;
    for (int i = 0; i < (1<<AW); i++) shadow[i] = init_word(i);
    forever begin
      @(negedge clk1); #2;
      if (!rst_n) begin
        pend = 0; streak = 0;
      end else if (pend) begin
        if (cyc == t_ack) pend = 0;
      end else if (bus.if_req || bus.dm_req) begin
        g = bus.dm_req && !(bus.if_req && streak == STREAK);
        if (g && bus.if_req) streak = (streak < STREAK) ? streak + 1 : streak;
        else                 streak = 0;
        pend = 1; t0 = cyc; t_ack = cyc + LAT + 2;
        cur_dm = g; cur_we = g && bus.dm_we;
        cur_addr = g ? bus.dm_addr : bus.if_addr;
        cur_wdata = bus.dm_wdata;
        r.dm = g; r.t = t_ack; r.has_data = !cur_we; r.data = shadow[cur_addr];
        if (cur_we) shadow[cur_addr] = cur_wdata;
        exp_q.push_back(r);
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [DW-1:0] last_if = '0, last_dm = '0;
    bit dm_known = 1, e_iss, e_ack;
    exp_t r;
    forever begin
      @(negedge clk1); #1;
      if (!rst_n) begin
        exp_q.delete(); last_if = '0; last_dm = '0; dm_known = 1;
      end else begin
        e_iss = pend && cyc == t0 + 1;
        e_ack = pend && cyc == t_ack;
        chk("busy", bus.busy, pend);
        chk("mem_en", bus.mem_en, e_iss);
        chk("mem_we", bus.mem_we, e_iss && cur_we);
        if (e_iss) chk("mem_addr", bus.mem_addr, cur_addr);
        if (e_iss && cur_we) chk("mem_wdata", bus.mem_wdata, cur_wdata);
        chk("if_ack", bus.if_ack, e_ack && !cur_dm);
        chk("dm_ack", bus.dm_ack, e_ack && cur_dm);
        chk("stall_if", bus.stall_if, bus.if_req && !(e_ack && !cur_dm));
        chk("stall_mem", bus.stall_mem, bus.dm_req && !(e_ack && cur_dm));
        if (bus.if_ack || bus.dm_ack) begin
          order_q.push_back(bus.dm_ack);
          if (exp_q.size() == 0) chk("unexpected_ack", 1, 0);
          else begin
            r = exp_q.pop_front();
            chk("ack_owner", bus.dm_ack, r.dm);
            chk("ack_cycle", cyc, r.t);
            if (r.dm) begin
              dm_known = r.has_data;
              if (r.has_data) last_dm = r.data;
            end else last_if = r.data;
          end
        end
        chk("if_rdata", bus.if_rdata, last_if);
        if (dm_known) chk("dm_rdata", bus.dm_rdata, last_dm);
      end
    end
  end

  task automatic wait_ack(input bit dm, input string nm);
    bit got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk1); #1;
      got = dm ? bus.dm_ack : bus.if_ack;
    end
    if (!got) begin
      nv++; nf++;
      $display("FAIL %s: got no ack expected ack within 400 cycles", nm);
    end
    @(posedge clk1); #1;
  endtask

  task automatic if_access(input logic [AW-1:0] a);
    bus.if_addr = a; bus.if_req = 1'b1;
    wait_ack(1'b0, "if_timeout");
    bus.if_req = 1'b0;
  endtask

  task automatic dm_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.dm_we = we; bus.dm_addr = a; bus.dm_wdata = d; bus.dm_req = 1'b1;
    wait_ack(1'b1, "dm_timeout");
    bus.dm_req = 1'b0;
  endtask

  task automatic reset_zero_checks(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_mem_en"}, bus.mem_en, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_if_ack"}, bus.if_ack, 0);
    chk({tag, "_dm_ack"}, bus.dm_ack, 0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 0);
    chk({tag, "_dm_rdata"}, bus.dm_rdata, 0);
  endtask

  initial begin
    int k0;
    bit got;
    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0;
    repeat (3) @(posedge clk1);
    #3 reset_zero_checks("reset");
    rst_n = 1'b1;
    @(posedge clk1); #1;

    // single fetch
    if_access(10'd0);
    chk("fetch_data", bus.if_rdata, 32'h480200d2);

    // simultaneous: data first, then fetch
    order_q.delete();
    fork
      if_access(10'd1);
      dm_access(1'b0, 10'd210, '0);
    join
    chk("simul_dm_data", bus.dm_rdata, 32'd40);
    chk("simul_order_len", order_q.size(), 2);
    if (order_q.size() == 2) begin
      chk("simul_first_dm", order_q[0], 1);
      chk("simul_second_if", order_q[1], 0);
    end

    // store then load
    dm_access(1'b1, 10'd198, 32'd362880);
    dm_access(1'b0, 10'd198, '0);
    chk("store_load_data", bus.dm_rdata, 32'd362880);

    // starvation guard
    order_q.delete();
    fork
      if_access(10'd7);
      for (int i = 0; i < 6; i++) dm_access(1'b0, 10'(200 + i), '0);
    join
    chk("starve_len", order_q.size(), 7);
    if (order_q.size() >= 6)
      for (int i = 0; i < 6; i++) chk($sformatf("starve_grant%0d", i), order_q[i], (i == 4) ? 0 : 1);

    // randomized mixed traffic
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk1); #1; end
        if_access(10'($urandom_range(192, 255)));
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk1); #1; end
        dm_access(1'($urandom_range(0, 1)), 10'($urandom_range(192, 223)), $urandom);
      end
    join

    // reset in the middle of a load, request held across reset
    bus.dm_we = 0; bus.dm_addr = 10'd300; bus.dm_req = 1'b1;
    repeat (2) @(posedge clk1);
    #3 rst_n = 1'b0;
    #1 reset_zero_checks("midrst");
    @(posedge clk1);
    #3 k0 = cyc; rst_n = 1'b1;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk1); #1;
      got = bus.dm_ack;
    end
    chk("midrst_ack_cycle", cyc, k0 + LAT + 2);
    chk("midrst_data", bus.dm_rdata, init_word(300));
    @(posedge clk1); #1 bus.dm_req = 1'b0;
    repeat (4) @(posedge clk1);
    #1 chk("end_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port unified memory between two requesters of the RISC-V pipeline: the instruction fetch port (IF, read-only) and the data port (MEM stage, load/store).
- Arbitrates between them, sequences each access through a fixed-latency memory, and returns data with a one-cycle ack pulse.
- Drives stall flags back to the pipeline hazard logic while a request is pending.
- Data port has priority; a streak limit prevents fetch starvation.

Parameters:
AW, 10, memory word-address width
DW, 32, data/instruction width
MEM_LAT, 1, cycles from mem_en to valid mem_rdata (>=1)
DM_STREAK_MAX, 4, max consecutive data-port grants while IF is waiting (>=1)

Ports:
clk1  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  AW  fetch word address
if_ack  out  1  one-cycle pulse, fetch complete
if_rdata  out  DW  fetched instruction, valid from if_ack cycle until next if grant
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1=store, 0=load
dm_addr  in  AW  data word address
dm_wdata  in  DW  store data
dm_ack  out  1  one-cycle pulse, data access complete
dm_rdata  out  DW  load data, valid from dm_ack cycle until next dm grant
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
stall_if  out  1  if_req & ~if_ack
stall_mem  out  1  dm_req & ~dm_ack
busy  out  1  FSM not in IDLE

Behaviour:
- Reset, asynchronous and immediate:
  - FSM=IDLE, streak counter=0.
  - All registered outputs go to 0: if_ack, dm_ack, if_rdata, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata.
- FSM states IDLE -> ISSUE -> WAIT -> ACK -> IDLE. All outputs except stall_* and busy are registered.
- IDLE: sample requests each cycle.
  - If any request is pending, grant it, latch owner, we, addr and wdata, then go to ISSUE.
  - Latched values are frozen; request-input changes during the access are ignored.
- Grant rule:
  - dm_req alone -> dm. if_req alone -> if.
  - Both pending -> dm, unless streak==DM_STREAK_MAX, in which case if.
- Streak counter:
  - +1 on a dm grant while if_req=1.
  - Cleared on any if grant, or on a dm grant while if_req=0.
  - Saturates at DM_STREAK_MAX.
- ISSUE (1 cycle): mem_en=1, mem_addr and mem_we driven from latched values; mem_wdata driven for stores. IF accesses always have mem_we=0.
- WAIT: lasts MEM_LAT cycles counted from the ISSUE cycle. At the end of the cycle where mem_rdata is valid (ISSUE+MEM_LAT), capture mem_rdata into the owner's rdata register, then go to ACK. Stores also pass through WAIT, so timing is uniform.
- ACK (1 cycle): owner's ack=1; the other requester's rdata is untouched.
- Requester handshake:
  - The requester must drop req (or present a new request) at the edge ending the ACK cycle.
  - A req still high in the following IDLE cycle is treated as a new request.
- Latency:
  - Request sampled in IDLE cycle T -> mem_en at T+1 -> ack at T+MEM_LAT+2.
  - Throughput is one access per MEM_LAT+3 cycles.
- mem_we is never 1 outside ISSUE. mem_en never exceeds one cycle per access.
- Address arithmetic: none; addresses pass straight through, with no wrap or bounds checking.
- Reset mid-access:
  - The access is abandoned and no ack is issued.
  - A store already strobed in ISSUE may have completed in memory.
  - After reset release, still-held requests are arbitrated fresh from IDLE.

Test Plan:
- Reset: assert rst_n=0 asynchronously between edges -> all outputs 0 immediately, busy=0.
- Single fetch, MEM_LAT=1: mem[0]=32'h480200d2, if_req addr 0 sampled at T -> mem_en=1, mem_we=0, mem_addr=0 at T+1; if_ack pulse at T+3; if_rdata=32'h480200d2; stall_if=1 during T..T+2.
- Simultaneous requests: mem[210]=40, if_req addr 1 and dm_req load addr 210 both in cycle T -> dm_ack at T+3 with dm_rdata=40; IF granted at T+4 with if_ack at T+7; stall_if high T..T+6.
- Store then load: dm store addr 198, wdata 362880 -> exactly one cycle of mem_en=mem_we=1 with mem_wdata=362880, then dm_ack. A following load from addr 198 returns 362880, and mem_we stays 0 throughout the load.
- Starvation guard, DM_STREAK_MAX=4: dm_req re-asserted immediately after every ack while if_req is held -> grant order dm,dm,dm,dm,if,dm...; streak returns to 0 after the IF grant.
- Reset mid-access, MEM_LAT=3: dm load in WAIT, pulse rst_n low -> no dm_ack, mem_en=0 immediately. Release reset with dm_req still high -> load restarts from IDLE and acks MEM_LAT+2 cycles after the first IDLE sample.
